// File: rtl/inference_sequencer.sv
// inference_sequencer
//   Launches one input vector into a pipelined network, waits for the rising
//   edge of the last stage's done signal (bounded by a timeout), lets the
//   result settle for RESULT_LAT cycles, then holds it on a valid/ready
//   output port until it is taken.
//
// Ports
//   clk        in   single clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   s_valid    in   upstream vector valid
//   s_ready    out  vector accepted this cycle (IDLE, or OUT while m_ready)
//   s_data     in   input vector, DATA_WIDTH*IN_COUNT bits
//   nn_in      out  registered vector presented to the network
//   nn_first   out  one-cycle launch pulse
//   nn_done    in   done of the last hidden stage
//   nn_result  in   network classification
//   m_valid    out  held result valid
//   m_ready    in   downstream takes the result
//   m_result   out  captured classification (4'hF on timeout)
//   m_timeout  out  held result came from a timeout
//   busy       out  sequencer not idle
//   inf_count  out  completed output handshakes, wraps at 16 bits
//
// state  | meaning
// IDLE   | waiting for an input vector
// LAUNCH | nn_first pulse, wait counter cleared
// WAIT   | waiting for a rising edge on nn_done or the timeout
// SETTLE | counting down RESULT_LAT before sampling nn_result
// OUT    | result held until m_ready
module inference_sequencer #(
    parameter int DATA_WIDTH     = 16,
    parameter int IN_COUNT       = 4,
    parameter int RESULT_LAT     = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [DATA_WIDTH*IN_COUNT-1:0] s_data,
    output logic [DATA_WIDTH*IN_COUNT-1:0] nn_in,
    output logic                           nn_first,
    input  logic                           nn_done,
    input  logic [3:0]                     nn_result,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [3:0]                     m_result,
    output logic                           m_timeout,
    output logic                           busy,
    output logic [15:0]                    inf_count
);

    localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int SET_W  = (RESULT_LAT > 0) ? $clog2(RESULT_LAT + 1) : 1;

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [SET_W-1:0]  SET_INIT  = SET_W'(RESULT_LAT);
    localparam logic [SET_W-1:0]  SET_ONE   = SET_W'(1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LAUNCH = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_SETTLE = 3'd3;
    localparam logic [2:0] ST_OUT    = 3'd4;

    logic [2:0]        state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [SET_W-1:0]  settle_cnt;
    logic              done_q;
    logic              accept;
    logic              handshake;
    logic              done_rise;

    // Gated by rst_n so every output reads zero while reset is held.
    assign s_ready   = rst_n && ((state == ST_IDLE) || ((state == ST_OUT) && m_ready));
    assign accept    = s_valid && s_ready;
    assign m_valid   = (state == ST_OUT);
    assign handshake = m_valid && m_ready;
    assign nn_first  = (state == ST_LAUNCH);
    assign busy      = (state != ST_IDLE);
    assign done_rise = nn_done && !done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            nn_in      <= '0;
            m_result   <= 4'h0;
            m_timeout  <= 1'b0;
            inf_count  <= 16'h0000;
            done_q     <= 1'b0;
            wait_cnt   <= '0;
            settle_cnt <= '0;
        end else begin
            done_q <= nn_done;
            if (accept) begin
                nn_in <= s_data;
            end
            if (handshake) begin
                inf_count <= inf_count + 16'd1;
            end
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    state    <= ST_WAIT;
                    wait_cnt <= '0;
                end
                ST_WAIT: begin
                    // A done edge takes priority over the timeout in the same cycle.
                    if (done_rise) begin
                        state      <= ST_SETTLE;
                        settle_cnt <= SET_INIT;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state     <= ST_OUT;
                        m_result  <= 4'hF;
                        m_timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_ONE;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == '0) begin
                        state     <= ST_OUT;
                        m_result  <= nn_result;
                        m_timeout <= 1'b0;
                    end else begin
                        settle_cnt <= settle_cnt - SET_ONE;
                    end
                end
                ST_OUT: begin
                    // accept can only be true here together with handshake.
                    if (handshake) begin
                        state <= accept ? ST_LAUNCH : ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inference_sequencer.sv
// tb_inference_sequencer
//   Directed bench for inference_sequencer with default parameters
//   (RESULT_LAT=2, TIMEOUT_CYCLES=1024, 64-bit vectors).
module tb_inference_sequencer;

    logic        clk;
    logic        rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [63:0] s_data;
    logic [63:0] nn_in;
    logic        nn_first;
    logic        nn_done;
    logic [3:0]  nn_result;
    logic        m_valid;
    logic        m_ready;
    logic [3:0]  m_result;
    logic        m_timeout;
    logic        busy;
    logic [15:0] inf_count;

    int n_cmp  = 0;
    int n_fail = 0;

    localparam logic [63:0] VEC_A = 64'h0001_0002_0003_0004;
    localparam logic [63:0] VEC_B = 64'hAAAA_5555_1234_8765;
    localparam logic [63:0] VEC_C = 64'h0F0F_F0F0_DEAD_BEEF;
    localparam logic [63:0] VEC_D = 64'h1111_2222_3333_4444;
    localparam logic [63:0] VEC_E = 64'h7777_8888_9999_0000;

    inference_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .nn_in     (nn_in),
        .nn_first  (nn_first),
        .nn_done   (nn_done),
        .nn_result (nn_result),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_result  (m_result),
        .m_timeout (m_timeout),
        .busy      (busy),
        .inf_count (inf_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        s_valid   = 1'b0;
        s_data    = '0;
        nn_done   = 1'b0;
        nn_result = 4'd0;
        m_ready   = 1'b0;
        #2;
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_nn_first", 64'(nn_first), 64'd0);
        chk("rst_nn_in", nn_in, 64'd0);
        chk("rst_inf_count", 64'(inf_count), 64'd0);
        tick(2);
        rst_n = 1'b1;
        #1;
        chk("post_rst_s_ready", 64'(s_ready), 64'd1);

        // Normal inference: done edge 20 cycles after launch, result 7.
        s_valid = 1'b1;
        s_data  = VEC_A;
        tick(1);
        s_valid = 1'b0;
        chk("a_nn_first", 64'(nn_first), 64'd1);
        chk("a_nn_in", nn_in, VEC_A);
        chk("a_busy", 64'(busy), 64'd1);
        chk("a_s_ready", 64'(s_ready), 64'd0);
        tick(1);
        chk("a_nn_first_one_cycle", 64'(nn_first), 64'd0);
        tick(19);
        nn_done   = 1'b1;
        nn_result = 4'd7;
        tick(1);
        chk("a_edge_m_valid", 64'(m_valid), 64'd0);
        tick(2);
        chk("a_edge2_m_valid", 64'(m_valid), 64'd0);
        tick(1);
        chk("a_m_valid", 64'(m_valid), 64'd1);
        chk("a_m_result", 64'(m_result), 64'd7);
        chk("a_m_timeout", 64'(m_timeout), 64'd0);
        m_ready = 1'b1;
        #1;
        chk("a_s_ready_out", 64'(s_ready), 64'd1);
        tick(1);
        m_ready = 1'b0;
        nn_done = 1'b0;
        chk("a_inf_count", 64'(inf_count), 64'd1);
        chk("a_idle_busy", 64'(busy), 64'd0);
        chk("a_idle_m_valid", 64'(m_valid), 64'd0);

        // Timeout: nn_done held low for the whole WAIT window.
        s_valid = 1'b1;
        s_data  = VEC_B;
        tick(1);
        s_valid = 1'b0;
        tick(1);
        tick(1023);
        chk("b_wait_1023_m_valid", 64'(m_valid), 64'd0);
        chk("b_wait_1023_busy", 64'(busy), 64'd1);
        tick(1);
        chk("b_m_valid", 64'(m_valid), 64'd1);
        chk("b_m_result", 64'(m_result), 64'hF);
        chk("b_m_timeout", 64'(m_timeout), 64'd1);

        // Back-pressure in OUT, then handshake with a new vector.
        s_valid = 1'b1;
        s_data  = VEC_C;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("c_hold_m_result", 64'(m_result), 64'hF);
            chk("c_hold_s_ready", 64'(s_ready), 64'd0);
        end
        chk("c_hold_m_valid", 64'(m_valid), 64'd1);
        chk("c_hold_nn_in", nn_in, VEC_B);
        m_ready = 1'b1;
        #1;
        chk("c_s_ready", 64'(s_ready), 64'd1);
        tick(1);
        s_valid = 1'b0;
        m_ready = 1'b0;
        chk("c_inf_count", 64'(inf_count), 64'd2);
        chk("c_nn_first", 64'(nn_first), 64'd1);
        chk("c_nn_in", nn_in, VEC_C);
        chk("c_m_valid", 64'(m_valid), 64'd0);
        tick(1);

        // Done edge in the same cycle the wait counter reaches 1023.
        tick(1023);
        nn_done   = 1'b1;
        nn_result = 4'd9;
        tick(1);
        chk("d_edge_wins_m_valid", 64'(m_valid), 64'd0);
        chk("d_edge_wins_busy", 64'(busy), 64'd1);
        tick(3);
        chk("d_m_valid", 64'(m_valid), 64'd1);
        chk("d_m_result", 64'(m_result), 64'd9);
        chk("d_m_timeout", 64'(m_timeout), 64'd0);
        m_ready = 1'b1;
        tick(1);
        m_ready = 1'b0;
        nn_done = 1'b0;
        chk("d_inf_count", 64'(inf_count), 64'd3);

        // Reset pulsed during SETTLE.
        s_valid = 1'b1;
        s_data  = VEC_D;
        tick(1);
        s_valid = 1'b0;
        tick(2);
        nn_done   = 1'b1;
        nn_result = 4'd5;
        tick(1);
        rst_n = 1'b0;
        #1;
        chk("e_rst_busy", 64'(busy), 64'd0);
        chk("e_rst_nn_in", nn_in, 64'd0);
        chk("e_rst_m_result", 64'(m_result), 64'd0);
        chk("e_rst_m_timeout", 64'(m_timeout), 64'd0);
        chk("e_rst_m_valid", 64'(m_valid), 64'd0);
        chk("e_rst_inf_count", 64'(inf_count), 64'd0);
        chk("e_rst_s_ready", 64'(s_ready), 64'd0);
        tick(1);
        rst_n = 1'b1;
        #1;
        chk("e_post_rst_s_ready", 64'(s_ready), 64'd1);
        tick(1);
        nn_done = 1'b0;
        tick(1);
        nn_done = 1'b1;
        tick(6);
        chk("e_ignored_busy", 64'(busy), 64'd0);
        chk("e_ignored_m_valid", 64'(m_valid), 64'd0);
        nn_done = 1'b0;
        tick(1);

        // Counter wrap: preset to 16'hFFFF, one more handshake gives 0.
        force dut.inf_count = 16'hFFFF;
        #1;
        release dut.inf_count;
        s_valid = 1'b1;
        s_data  = VEC_E;
        tick(1);
        s_valid = 1'b0;
        tick(2);
        nn_done   = 1'b1;
        nn_result = 4'd3;
        tick(4);
        chk("f_m_valid", 64'(m_valid), 64'd1);
        chk("f_m_result", 64'(m_result), 64'd3);
        m_ready = 1'b1;
        tick(1);
        m_ready = 1'b0;
        nn_done = 1'b0;
        chk("f_inf_count_wrap", 64'(inf_count), 64'd0);
        chk("f_idle_busy", 64'(busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/inference_sequencer.md
INFERENCE_SEQUENCER -- requirements
Module: inference_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, bit width of one input element.
REQ-002 SHALL have parameter IN_COUNT, default 4, number of elements in one input vector.
REQ-003 SHALL have parameter RESULT_LAT, default 2, clk cycles from last-stage done rising edge to a valid nn_result.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1024, maximum clk cycles spent in WAIT.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all flops on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port s_valid, input, 1 bit: upstream input vector valid.
REQ-008 SHALL have port s_ready, output, 1 bit: sequencer accepts the vector this cycle.
REQ-009 SHALL have port s_data, input, DATA_WIDTH*IN_COUNT bits: input vector.
REQ-010 SHALL have port nn_in, output, DATA_WIDTH*IN_COUNT bits: registered vector driven to the network input.
REQ-011 SHALL have port nn_first, output, 1 bit: one-cycle launch pulse to the network.
REQ-012 SHALL have port nn_done, input, 1 bit: done output of the last hidden stage.
REQ-013 SHALL have port nn_result, input, 4 bits: network classification.
REQ-014 SHALL have port m_valid, output, 1 bit: result held and valid.
REQ-015 SHALL have port m_ready, input, 1 bit: downstream accepts the result.
REQ-016 SHALL have port m_result, output, 4 bits: captured classification.
REQ-017 SHALL have port m_timeout, output, 1 bit: the held result was produced by a timeout.
REQ-018 SHALL have port busy, output, 1 bit: state is not IDLE.
REQ-019 SHALL have port inf_count, output, 16 bits: completed output handshakes.

Function
REQ-020 SHALL implement states IDLE, LAUNCH, WAIT, SETTLE, OUT.
REQ-021 SHALL assert s_ready combinationally when in IDLE, or when in OUT with m_ready=1.
REQ-022 SHALL, on s_valid&&s_ready, register s_data into nn_in and go to LAUNCH; nn_in SHALL hold otherwise.
REQ-023 SHALL assert nn_first for exactly the one LAUNCH cycle, then go to WAIT with the wait counter cleared.
REQ-024 SHALL register nn_done each cycle and detect a rising edge as nn_done=1 with registered value 0.
REQ-025 SHALL, in WAIT, go to SETTLE on a rising edge, loading the settle counter with RESULT_LAT.
REQ-026 SHALL, in WAIT with no edge and the wait counter at TIMEOUT_CYCLES-1, go to OUT with m_result=4'hF and m_timeout=1.
REQ-027 SHALL let a rising edge win over timeout when both occur in the same cycle.
REQ-028 SHALL ignore nn_done edges outside WAIT.
REQ-029 SHALL, in SETTLE, decrement the counter each cycle and, at 0, capture nn_result into m_result with m_timeout=0 and go to OUT; RESULT_LAT=0 SHALL capture in the first SETTLE cycle.
REQ-030 SHALL assert m_valid only in OUT and hold m_result and m_timeout stable until m_valid&&m_ready.
REQ-031 SHALL, on m_valid&&m_ready, increment inf_count (wrapping 16'hFFFF to 0) and go to IDLE, or to LAUNCH if s_valid is also accepted that cycle.
REQ-032 SHALL drive busy=1 in every state except IDLE.

Reset
REQ-033 SHALL, with rst_n=0 at any time including mid-inference, asynchronously force IDLE with nn_in=0, nn_first=0, m_valid=0, m_result=0, m_timeout=0, inf_count=0, the registered nn_done=0, and both counters=0.
REQ-034 SHALL drive s_ready=1 in the first cycle after rst_n deasserts.

Verification
REQ-035 Bench SHALL cover: s_data=64'h0001_0002_0003_0004 accepted -> nn_first high exactly 1 cycle later; nn_done rises 20 cycles later with nn_result=4'd7 -> m_valid 3 cycles after the edge (RESULT_LAT=2), m_result=7, m_timeout=0.
REQ-036 Bench SHALL cover: nn_done held 0 after launch -> m_valid after 1024 WAIT cycles with m_result=4'hF, m_timeout=1.
REQ-037 Bench SHALL cover: m_ready=0 for 10 cycles in OUT -> m_result stable, s_ready=0; then m_ready=1 with s_valid=1 -> inf_count+1 and LAUNCH next cycle.
REQ-038 Bench SHALL cover: rst_n pulsed low during SETTLE -> all outputs zero immediately, s_ready=1 after release, later nn_done edge ignored.
REQ-039 Bench SHALL cover: inf_count preset by 65535 handshakes -> next handshake gives inf_count=0.
REQ-040 Bench SHALL cover: nn_done edge in the same cycle as the wait counter reaches 1023 -> SETTLE, m_timeout=0.
